// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, entry format and trigger decode for the UART receive path
package uart_pkg;

  localparam int DEPTH = 16;
  localparam logic [9:0] TMO_LIMIT = 10'd640;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_e;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [4:0] trig_level(input logic [1:0] sel);
    case (trig_e'(sel))
      TRIG_1:  return 5'd1;
      TRIG_4:  return 5'd4;
      TRIG_8:  return 5'd8;
      default: return 5'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16-entry show-ahead receive buffer with selectable depth of one
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      clr,
  input  logic      one_deep,
  input  rx_entry_t din,
  output rx_entry_t dout,
  output logic      full,
  output logic      empty,
  output logic [4:0] level,
  output logic      push_ok,
  output logic      pop_ok
);

  rx_entry_t  mem [DEPTH];
  rx_entry_t  last_q;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [4:0] cnt;

  assign empty   = (cnt == 5'd0);
  assign full    = (cnt == (one_deep ? 5'd1 : 5'(DEPTH)));
  // A pop frees the slot in the same cycle, so a full buffer still takes push+pop.
  assign push_ok = push && !clr && (!full || pop);
  assign pop_ok  = pop && !clr && !empty;
  assign level   = cnt;
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      cnt    <= 5'd0;
      last_q <= '0;
    end else begin
      if (!empty) last_q <= mem[rd_ptr];
      if (clr) begin
        wr_ptr <= 4'd0;
        rd_ptr <= 4'd0;
        cnt    <= 5'd0;
      end else begin
        wr_ptr <= wr_ptr + {3'd0, push_ok};
        rd_ptr <= rd_ptr + {3'd0, pop_ok};
        cnt    <= cnt + {4'd0, push_ok} - {4'd0, pop_ok};
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive control: baud strobe, receive buffer, line status and interrupts
module uart_rx_ctrl
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  output logic        baud_pulse,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pe_in,
  input  logic        fe_in,
  input  logic        bi_in,
  input  logic        pop,
  input  logic        lsr_rd,
  input  logic        fifo_en,
  input  logic        fifo_clr,
  input  logic [1:0]  trig,
  output logic [7:0]  dout,
  output logic        dr,
  output logic        pe,
  output logic        fe,
  output logic        bi,
  output logic        oe,
  output logic        fifo_err,
  output logic        rx_irq,
  output logic        tmo_irq,
  output logic [4:0]  level
);

  logic [15:0] baud_cnt;
  logic        fifo_en_q;
  logic        clr_eff;
  rx_entry_t   wr_entry;
  rx_entry_t   head;
  logic        full;
  logic        empty;
  logic        push_ok;
  logic        pop_ok;
  logic        overrun;
  logic [4:0]  err_cnt;
  logic [9:0]  tmo_cnt;
  logic [9:0]  tmo_next;

  // Counter starts at zero so the first cycle out of reset loads div.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt   <= 16'd0;
      baud_pulse <= 1'b0;
    end else if (baud_cnt <= 16'd1) begin
      baud_cnt   <= div;
      baud_pulse <= (div != 16'd0);
    end else begin
      baud_cnt   <= baud_cnt - 16'd1;
      baud_pulse <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fifo_en_q <= 1'b0;
    else     fifo_en_q <= fifo_en;
  end

  assign clr_eff  = fifo_clr || (fifo_en != fifo_en_q);
  assign wr_entry = '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};

  uart_rx_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clr      (clr_eff),
    .one_deep (!fifo_en),
    .din      (wr_entry),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok)
  );

  assign dout     = head.data;
  assign pe       = head.pe;
  assign fe       = head.fe;
  assign bi       = head.bi;
  assign dr       = !empty;
  assign overrun  = push && full && !pop && !clr_eff;
  assign fifo_err = (err_cnt != 5'd0);
  assign rx_irq   = fifo_en ? (level >= trig_level(trig)) : dr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          oe <= 1'b0;
    else if (overrun) oe <= 1'b1;
    else if (lsr_rd)  oe <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_cnt <= 5'd0;
    else if (clr_eff) err_cnt <= 5'd0;
    else err_cnt <= err_cnt
                  + {4'd0, push_ok && (pe_in || fe_in || bi_in)}
                  - {4'd0, pop_ok && (head.pe || head.fe || head.bi)};
  end

  always_comb begin
    tmo_next = tmo_cnt;
    if (clr_eff || push || pop || empty) tmo_next = 10'd0;
    else if (baud_pulse && tmo_cnt != TMO_LIMIT) tmo_next = tmo_cnt + 10'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 10'd0;
      tmo_irq <= 1'b0;
    end else begin
      tmo_cnt <= tmo_next;
      tmo_irq <= (tmo_next == TMO_LIMIT);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized and directed checks of uart_rx_ctrl against a queue-based model
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        baud_pulse;
  logic        push;
  logic [7:0]  din;
  logic        pe_in, fe_in, bi_in;
  logic        pop, lsr_rd, fifo_en, fifo_clr;
  logic [1:0]  trig;
  logic [7:0]  dout;
  logic        dr, pe, fe, bi, oe, fifo_err, rx_irq, tmo_irq;
  logic [4:0]  level;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .div(div), .baud_pulse(baud_pulse),
    .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
    .pop(pop), .lsr_rd(lsr_rd), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
    .trig(trig), .dout(dout), .dr(dr), .pe(pe), .fe(fe), .bi(bi),
    .oe(oe), .fifo_err(fifo_err), .rx_irq(rx_irq), .tmo_irq(tmo_irq),
    .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [10:0] q[$];
  logic [10:0] m_last;
  logic        m_oe, m_pulse, m_tirq, m_en_q;
  int          m_bcnt, m_tcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int trig_lvl(input logic [1:0] t);
    int lv [4] = '{1, 4, 8, 14};
    return lv[t];
  endfunction

  function automatic int err_entries();
    int n = 0;
    foreach (q[i]) if (q[i][10:8] != 3'b000) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last = '0; m_oe = 0; m_pulse = 0; m_tirq = 0; m_en_q = 0;
    m_bcnt = 0;  m_tcnt = 0;
  endtask

  task automatic model_step();
    bit clr, full, old_pulse;
    int dep;
    clr    = fifo_clr || (fifo_en != m_en_q);
    m_en_q = fifo_en;
    dep    = fifo_en ? 16 : 1;
    old_pulse = m_pulse;
    if (m_bcnt <= 1) begin
      m_pulse = (div != 0);
      m_bcnt  = div;
    end else begin
      m_pulse = 0;
      m_bcnt--;
    end
    if (clr || push || pop || q.size() == 0) m_tcnt = 0;
    else if (old_pulse && m_tcnt < 640) m_tcnt++;
    m_tirq = (m_tcnt >= 640);
    if (q.size() > 0) m_last = q[0];
    full = (q.size() == dep);
    if (push && full && !pop && !clr) m_oe = 1;
    else if (lsr_rd) m_oe = 0;
    if (clr) q.delete();
    else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push && (!full || pop)) q.push_back({bi_in, fe_in, pe_in, din});
    end
  endtask

  function automatic logic [21:0] got_vec();
    return {baud_pulse, dout, dr, pe, fe, bi, oe, fifo_err, rx_irq, tmo_irq, level};
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [10:0] h;
    logic irq;
    h   = (q.size() > 0) ? q[0] : m_last;
    irq = fifo_en ? (q.size() >= trig_lvl(trig)) : (q.size() > 0);
    return {m_pulse, h[7:0], q.size() > 0, h[8], h[9], h[10], m_oe,
            err_entries() > 0, irq, m_tirq, 5'(q.size())};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check("outputs", 32'(got_vec()), 32'(exp_vec()));
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; lsr_rd = 0; fifo_clr = 0;
    pe_in = 0; fe_in = 0; bi_in = 0;
  endtask

  task automatic do_push(input logic [7:0] d, input logic f);
    push = 1; din = d; fe_in = f;
    cyc();
    push = 0; fe_in = 0;
  endtask

  task automatic do_pop();
    pop = 1; cyc(); pop = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    model_reset();
    for (int i = 0; i < n; i++) cyc();
    rst = 0;
  endtask

  task automatic flush();
    fifo_clr = 1; cyc(); fifo_clr = 0;
  endtask

  int cnt;

  initial begin
    rst = 1; div = 16'd4; din = 8'h00; trig = 2'b00; fifo_en = 0;
    idle_inputs();
    model_reset();
    #1;
    check("reset_outputs", 32'(got_vec()), 32'd0);
    do_reset(3);
    check("reset_level", 32'(level), 32'd0);

    // Baud strobe: div=4 then div=0
    for (int i = 0; i < 4; i++) cyc();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin cyc(); cnt += baud_pulse; end
    check("baud_div4_count", cnt, 10);
    div = 16'd0;
    for (int i = 0; i < 12; i++) cyc();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin cyc(); cnt += baud_pulse; end
    check("baud_div0_count", cnt, 0);

    // In-order show-ahead reads
    fifo_en = 1; cyc(); cyc();
    do_push(8'h41, 0); do_push(8'h42, 0); do_push(8'h43, 0);
    check("order_0", dout, 8'h41); do_pop();
    check("order_1", dout, 8'h42); do_pop();
    check("order_2", dout, 8'h43); do_pop();
    check("order_dr", dr, 1'b0);

    // Overrun on 17th push
    flush();
    for (int i = 0; i < 17; i++) do_push(8'h10 + 8'(i), 0);
    check("ovr_level", level, 5'd16);
    check("ovr_oe", oe, 1'b1);
    for (int i = 0; i < 15; i++) do_pop();
    check("ovr_last_kept", dout, 8'h1f);
    do_pop();
    check("ovr_empty", level, 5'd0);
    lsr_rd = 1; cyc(); lsr_rd = 0;
    check("ovr_lsr_clear", oe, 1'b0);

    // Trigger level and error tracking
    trig = 2'b01;
    for (int i = 0; i < 3; i++) do_push(8'h20 + 8'(i), 0);
    check("trig_lvl3", rx_irq, 1'b0);
    do_push(8'h55, 1);
    check("trig_lvl4", rx_irq, 1'b1);
    check("ferr_set", fifo_err, 1'b1);
    for (int i = 0; i < 3; i++) do_pop();
    check("ferr_held", fifo_err, 1'b1);
    do_pop();
    check("ferr_clear", fifo_err, 1'b0);

    // Character timeout
    div = 16'd1;
    for (int i = 0; i < 4; i++) cyc();
    do_push(8'h77, 0);
    for (int i = 0; i < 639; i++) cyc();
    check("tmo_before", tmo_irq, 1'b0);
    cyc();
    check("tmo_at_640", tmo_irq, 1'b1);
    for (int i = 0; i < 20; i++) cyc();
    check("tmo_saturate", tmo_irq, 1'b1);
    do_pop();
    check("tmo_pop_clear", tmo_irq, 1'b0);

    // Non-FIFO mode overrun, then reset with entries pending
    fifo_en = 0; cyc();
    do_push(8'hA1, 0); do_push(8'hB2, 0);
    check("nofifo_dout", dout, 8'hA1);
    check("nofifo_oe", oe, 1'b1);
    fifo_en = 1; cyc();
    for (int i = 0; i < 5; i++) do_push(8'(i), 1);
    check("pre_rst_level", level, 5'd5);
    push = 1;
    do_reset(2);
    push = 0;
    #1;
    check("rst_outputs", 32'(got_vec()), 32'd0);

    // Randomized traffic
    div = 16'd3;
    for (int i = 0; i < 4000; i++) begin
      bit fill = (i / 250) % 2 == 0;
      idle_inputs();
      push   = fill ? ($urandom % 2 == 0) : ($urandom % 5 == 0);
      pop    = fill ? ($urandom % 5 == 0) : ($urandom % 2 == 0);
      din    = 8'($urandom);
      pe_in  = ($urandom % 8 == 0);
      fe_in  = ($urandom % 8 == 0);
      bi_in  = ($urandom % 8 == 0);
      lsr_rd = ($urandom % 8 == 0);
      fifo_clr = ($urandom % 97 == 0);
      if ($urandom % 211 == 0) fifo_en = ~fifo_en;
      if ($urandom % 50 == 0)  trig = 2'($urandom);
      if ($urandom % 150 == 0) div = 16'($urandom % 6);
      if ($urandom % 700 == 0) do_reset(2);
      else cyc();
    end
    idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
